// File: rtl/colour_pkg.sv
// colour_pkg: shared definitions for the ColourMemory2000 datapath.
//   Colour codes (one-hot nibbles, 0 = unlit), LFSR feedback taps,
//   the sequence generator FSM state type and small colour helpers.
package colour_pkg;

  localparam logic [3:0]  C_BLACK  = 4'd0;
  localparam logic [3:0]  C_GREEN  = 4'd1;
  localparam logic [3:0]  C_RED    = 4'd2;
  localparam logic [3:0]  C_BLUE   = 4'd4;
  localparam logic [3:0]  C_YELLOW = 4'd8;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {S_IDLE, S_FILL} seq_state_e;

  // Colour draw from the LFSR: one-hot of the two low bits.
  // Takes the whole state so callers need not slice it.
  function automatic logic [3:0] colour_draw(input logic [15:0] s);
    logic [3:0] c;
    case (s[1:0])
      2'd0:    c = C_GREEN;
      2'd1:    c = C_RED;
      2'd2:    c = C_BLUE;
      default: c = C_YELLOW;
    endcase
    return c;
  endfunction

  // Rotate a colour nibble left by one (yellow wraps to green).
  function automatic logic [3:0] rotl4(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, shifts every clock.
//   clock : system clock
//   reset : asynchronous active-high reset, loads SEED
//   state : current register contents, never zero
module lfsr16
  import colour_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  // An all-zero state would lock the register up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h0001 : SEED;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SEED_NZ;
    else       state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0);
  end

endmodule

// File: rtl/colour_sequence_gen.sv
// colour_sequence_gen: builds the packed one-hot colour sequence for the
// game FSM, refilling it on every newGame / nextLevel request.
//   clock, reset     : system clock, async active-high reset
//   newGame          : pulse, length <= INIT_LENGTH and refill (wins ties)
//   nextLevel        : pulse, length <= length+1 (saturating) and refill
//   coloursequence   : slot i at [4i+3:4i]; valid slots one-hot, rest 0
//   seqLength        : number of valid slots
//   busy             : fill in progress (MAX_LENGTH cycles)
//   seqValid         : last fill completed
//   levelMaxed       : seqLength == MAX_LENGTH
module colour_sequence_gen
  import colour_pkg::*;
#(
  parameter int          MAX_LENGTH  = 8,
  parameter int          INIT_LENGTH = 3,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         LENW        = $clog2(MAX_LENGTH + 1),
  localparam int         IDXW        = $clog2(MAX_LENGTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    newGame,
  input  logic                    nextLevel,
  output logic [4*MAX_LENGTH-1:0] coloursequence,
  output logic [LENW-1:0]         seqLength,
  output logic                    busy,
  output logic                    seqValid,
  output logic                    levelMaxed
);

  localparam logic [LENW-1:0] LEN_INIT = LENW'(INIT_LENGTH);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_LENGTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(MAX_LENGTH - 1);

  seq_state_e                        state_q;
  logic [IDXW-1:0]                   idx_q;
  logic [MAX_LENGTH-1:0][3:0]        seq_q;
  logic [LENW-1:0]                   len_q, len_d;
  logic                              busy_q, valid_q, maxed_q;
  logic [15:0]                       lfsr_q;
  logic [3:0]                        col, prev, slot_d;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .state (lfsr_q)
  );

  always_comb begin
    col    = colour_draw(lfsr_q);
    prev   = (idx_q != '0) ? seq_q[idx_q - IDXW'(1)] : C_BLACK;
    // Slot 0 compares against black, which a drawn colour never equals.
    slot_d = C_BLACK;
    if (LENW'(idx_q) < len_q) slot_d = (col == prev) ? rotl4(col) : col;

    len_d = len_q;
    if (newGame)        len_d = LEN_INIT;
    else if (nextLevel) len_d = (len_q == LEN_MAX) ? len_q : len_q + LENW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      seq_q   <= '0;
      len_q   <= LEN_INIT;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      maxed_q <= (INIT_LENGTH == MAX_LENGTH);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (newGame || nextLevel) begin
            len_q   <= len_d;
            maxed_q <= (len_d == LEN_MAX);
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          // Requests here are dropped, not queued.
          seq_q[idx_q] <= slot_d;
          if (idx_q == IDX_LAST) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coloursequence = seq_q;
  assign seqLength      = len_q;
  assign busy           = busy_q;
  assign seqValid       = valid_q;
  assign levelMaxed     = maxed_q;

endmodule

// File: tb/tb_colour_sequence_gen.sv
// Directed bench for colour_sequence_gen with default parameters.
module tb_colour_sequence_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        newGame = 1'b0;
  logic        nextLevel = 1'b0;
  logic [31:0] coloursequence;
  logic [3:0]  seqLength;
  logic        busy, seqValid, levelMaxed;

  int passed = 0;
  int total  = 0;

  colour_sequence_gen #(.MAX_LENGTH(8), .INIT_LENGTH(3), .SEED(16'hACE1)) dut (
    .clock          (clock),
    .reset          (reset),
    .newGame        (newGame),
    .nextLevel      (nextLevel),
    .coloursequence (coloursequence),
    .seqLength      (seqLength),
    .busy           (busy),
    .seqValid       (seqValid),
    .levelMaxed     (levelMaxed)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR tracking the DUT's free-running one.
  logic [15:0] m_lfsr;
  always @(posedge clock or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= step(m_lfsr);

  // Expected sequence when the request edge sees LFSR value l0:
  // slot i is written at the (i+1)th following edge.
  function automatic logic [31:0] model_seq(input logic [15:0] l0, input int len);
    logic [15:0] l;
    logic [3:0]  c, p;
    logic [31:0] s;
    l = l0; p = 4'h0; s = '0;
    for (int i = 0; i < 8; i++) begin
      l = step(l);
      c = 4'b0001 << l[1:0];
      if (i < len) begin
        if (c == p) c = {c[2:0], c[3]};
        s[4*i +: 4] = c;
        p = c;
      end
    end
    return s;
  endfunction

  function automatic bit props_ok(input logic [31:0] s, input int len);
    logic [3:0] v;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = s[4*i +: 4];
      if (i < len) begin
        if (!(v == 4'h1 || v == 4'h2 || v == 4'h4 || v == 4'h8)) ok = 1'b0;
        if (i > 0 && v == s[4*(i-1) +: 4]) ok = 1'b0;
      end else if (v != 4'h0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one request at a negedge, then follow the fill to completion.
  // inject > 0 raises nextLevel for one cycle that many cycles into the fill.
  task automatic request(input bit ng, input bit nl, input string tag,
                         input int exp_len, input int inject, output logic [31:0] got);
    logic [15:0] l0;
    int n;
    l0 = m_lfsr;
    newGame = ng; nextLevel = nl;
    @(negedge clock);
    newGame = 1'b0; nextLevel = 1'b0;
    chk({tag, "_len"}, 64'(seqLength), 64'(exp_len));
    chk({tag, "_maxed"}, 64'(levelMaxed), 64'(exp_len == 8));
    chk({tag, "_valid_clr"}, 64'(seqValid), 64'd0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == inject) nextLevel = 1'b1;
      @(negedge clock);
      nextLevel = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'd8);
    chk({tag, "_valid"}, 64'(seqValid), 64'd1);
    chk({tag, "_len_hold"}, 64'(seqLength), 64'(exp_len));
    chk({tag, "_seq"}, 64'(coloursequence), 64'(model_seq(l0, exp_len)));
    chk({tag, "_props"}, 64'(props_ok(coloursequence, exp_len)), 64'd1);
    got = coloursequence;
  endtask

  logic [31:0] t1_seq, s, prev_s;
  logic [3:0]  seen;

  initial begin
    // 1: reset values, first fill
    repeat (3) @(negedge clock);
    chk("rst_seq",   64'(coloursequence), 64'd0);
    chk("rst_len",   64'(seqLength), 64'd3);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(seqValid), 64'd0);
    chk("rst_maxed", 64'(levelMaxed), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    request(1'b1, 1'b0, "t1", 3, 0, t1_seq);
    chk("t1_upper_zero", 64'(t1_seq[31:12]), 64'd0);

    // 2: climb to the maximum, then saturate
    for (int k = 4; k <= 8; k++) begin
      @(negedge clock);
      request(1'b0, 1'b1, "t2", k, 0, s);
    end
    prev_s = s;
    @(negedge clock);
    request(1'b0, 1'b1, "t2sat", 8, 0, s);
    chk("t2sat_differs", 64'(s != prev_s), 64'd1);

    // 3: simultaneous requests at length 5, newGame wins
    request(1'b1, 1'b0, "t3a", 3, 0, s);
    request(1'b0, 1'b1, "t3b", 4, 0, s);
    request(1'b0, 1'b1, "t3c", 5, 0, s);
    request(1'b1, 1'b1, "t3", 3, 0, s);
    @(negedge clock);
    chk("t3_single_fill", 64'(busy), 64'd0);

    // 4: nextLevel mid-fill is dropped
    request(1'b0, 1'b1, "t4", 4, 3, s);
    chk("t4_not_queued_busy", 64'(busy), 64'd0);
    @(negedge clock);
    chk("t4_not_queued_busy2", 64'(busy), 64'd0);
    chk("t4_not_queued_len", 64'(seqLength), 64'd4);

    // 5: asynchronous reset between edges mid-fill
    newGame = 1'b1;
    @(negedge clock);
    newGame = 1'b0;
    repeat (3) @(negedge clock);
    #3 reset = 1'b1;
    #1;
    chk("t5_seq",   64'(coloursequence), 64'd0);
    chk("t5_len",   64'(seqLength), 64'd3);
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_valid", 64'(seqValid), 64'd0);
    chk("t5_maxed", 64'(levelMaxed), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    request(1'b1, 1'b0, "t5", 3, 0, s);
    chk("t5_repeat_t1", 64'(s), 64'(t1_seq));

    // 6: random-timed newGame requests
    seen = 4'h0;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      request(1'b1, 1'b0, "t6", 3, 0, s);
      for (int i = 0; i < 3; i++) seen = seen | s[4*i +: 4];
    end
    chk("t6_all_colours", 64'(seen), 64'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
